// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. A fetch PC register addresses the
//               instruction memory; each fetched word (with its PC and a
//               fetch-address exception flag) is pushed into a circular
//               prefetch queue that the decode stage drains through a
//               valid/ready handshake. Redirects and interrupts flush the
//               queue and restart fetch from a new target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_4FFC,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     int_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_exc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            PW         = $clog2(DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // Fetch state
    logic [31:0]   fetch_pc;

    // Prefetch queue storage and bookkeeping
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          exc_mem   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] occ;

    // Per-cycle control
    logic          flush;
    logic          fetch_exc;
    logic [31:0]   push_instr;
    logic          deq;
    logic          push;

    assign imem_addr = fetch_pc;
    assign count     = occ;

    // Flush and exception classification of the current fetch address
    always_comb begin
        flush      = redirect_valid | int_req;
        // Misaligned or outside the instruction window (unsigned compares)
        fetch_exc  = (fetch_pc[1:0] != 2'b00) | (fetch_pc < IM_LO) | (fetch_pc > IM_HI);
        // A faulting fetch must not leak whatever the memory returns
        push_instr = fetch_exc ? 32'h0000_0000 : imem_data;
    end

    // Head presentation and handshake decode
    always_comb begin
        out_valid = (occ != '0) & ~flush;
        out_pc    = pc_mem[rd_ptr];
        out_instr = instr_mem[rd_ptr];
        out_exc   = exc_mem[rd_ptr];
        deq       = out_valid & out_ready;
        // A full queue still accepts a push when the head leaves this cycle
        push      = ((occ < FULL_COUNT) | deq) & ~flush;
    end

    // Fetch PC, pointers and occupancy; reset beats interrupt beats redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else if (flush) begin
            fetch_pc <= int_req ? EXC_PC : redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, deq})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Queue payload write; entries need no reset because occupancy gates them
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= push_instr;
            exc_mem[wr_ptr]   <= fetch_exc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A queue-based reference
//               model tracks the expected fetch PC and prefetch contents;
//               directed scenarios pin known values, then randomized traffic
//               exercises redirects, interrupts, resets and back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam logic [31:0] IM_HI    = 32'h0000_4FFC;
    localparam int          DEPTH    = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } entry_t;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        int_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;
    logic [$clog2(DEPTH):0] count;

    int     n_cmp;
    int     n_bad;
    bit     chk_en;
    entry_t mq[$];
    logic [31:0] mpc;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .EXC_PC   (EXC_PC),
        .IM_LO    (IM_LO),
        .IM_HI    (IM_HI),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .int_req        (int_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_exc        (out_exc),
        .count          (count)
    );

    // Instruction memory: every word is tagged with its own address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
    endfunction

    assign imem_data = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic near();
        @(negedge clk);
    endtask

    // Reference model: advances on every rising edge from the applied inputs
    always @(posedge clk) begin
        entry_t e;
        bit     take;
        bit     full;
        if (reset) begin
            mq.delete();
            mpc = RESET_PC;
        end else if (int_req) begin
            mq.delete();
            mpc = EXC_PC;
        end else if (redirect_valid) begin
            mq.delete();
            mpc = redirect_pc;
        end else begin
            take = (mq.size() != 0) && out_ready;
            full = (mq.size() == DEPTH);
            if (take) void'(mq.pop_front());
            if (!full || take) begin
                e.pc    = mpc;
                e.exc   = (mpc[1:0] != 2'b00) || (mpc < IM_LO) || (mpc > IM_HI);
                e.instr = e.exc ? 32'h0 : mem_word(mpc);
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    end

    // Compare DUT outputs against the model in the middle of every cycle
    always @(negedge clk) begin
        bit     exp_valid;
        entry_t h;
        if (chk_en) begin
            exp_valid = (mq.size() != 0) && !redirect_valid && !int_req;
            chk("imem_addr", imem_addr, mpc);
            chk("count", 32'(count), 32'(mq.size()));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                h = mq[0];
                chk("out_pc", out_pc, h.pc);
                chk("out_instr", out_instr, h.instr);
                chk("out_exc", 32'(out_exc), 32'(h.exc));
            end
        end
    end

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0, 1:    return IM_LO + 32'($urandom_range(0, 32'h7FF)) * 32'd4;
            2:       return IM_LO + 32'($urandom_range(0, 32'h7FF)) * 32'd4 + 32'($urandom_range(1, 3));
            3:       return 32'h0000_2FF0 + 32'($urandom_range(0, 3)) * 32'd4;
            4:       return 32'hFFFF_FFF4;
            default: return 32'h0000_4FF0;
        endcase
    endfunction

    initial begin
        int bias;
        n_cmp = 0;
        n_bad = 0;
        chk_en = 1'b0;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        int_req = 1'b0;
        out_ready = 1'b0;

        tick();
        chk_en = 1'b1;
        tick();
        near();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_3000);

        // Streaming with a always-ready consumer
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick(); near();
        chk("stream_pc0", out_pc, 32'h0000_3000);
        chk("stream_cnt0", 32'(count), 32'd1);
        chk("stream_exc0", 32'(out_exc), 32'd0);
        tick(); near();
        chk("stream_pc1", out_pc, 32'h0000_3004);
        chk("stream_cnt1", 32'(count), 32'd1);
        tick(); near();
        chk("stream_pc2", out_pc, 32'h0000_3008);

        // Back-pressure fills the queue, then it drains in order
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        repeat (10) tick();
        near();
        chk("full_cnt", 32'(count), 32'd4);
        chk("full_addr", imem_addr, 32'h0000_3010);
        chk("full_head", out_pc, 32'h0000_3000);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick(); near();
            chk("drain_pc", out_pc, 32'h0000_3000 + 32'(i) * 32'd4);
            chk("drain_cnt", 32'(count), 32'd4);
        end

        // Redirect with three entries queued
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_3400;
        near();
        chk("redir_cnt_before", 32'(count), 32'd3);
        chk("redir_valid_low", 32'(out_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        near();
        chk("redir_cnt_after", 32'(count), 32'd0);
        chk("redir_addr", imem_addr, 32'h0000_3400);
        tick(); near();
        chk("redir_head", out_pc, 32'h0000_3400);

        // Interrupt outranks a simultaneous redirect
        tick();
        int_req = 1'b1;
        redirect_valid = 1'b1;
        tick();
        int_req = 1'b0;
        redirect_valid = 1'b0;
        tick(); near();
        chk("int_head", out_pc, 32'h0000_4180);

        // Misaligned redirect target
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_3002;
        tick();
        redirect_valid = 1'b0;
        tick(); near();
        chk("mis_pc", out_pc, 32'h0000_3002);
        chk("mis_exc", 32'(out_exc), 32'd1);
        chk("mis_instr", out_instr, 32'h0);

        // Running off the top of the instruction window
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_4FFC;
        tick();
        redirect_valid = 1'b0;
        tick(); near();
        chk("top_pc", out_pc, 32'h0000_4FFC);
        chk("top_exc", 32'(out_exc), 32'd0);
        tick(); near();
        chk("over_pc", out_pc, 32'h0000_5000);
        chk("over_exc", 32'(out_exc), 32'd1);

        // Reset beats a redirect while the queue is full
        tick();
        out_ready = 1'b0;
        repeat (6) tick();
        near();
        chk("prerst_cnt", 32'(count), 32'd4);
        tick();
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_3400;
        tick();
        reset = 1'b0;
        redirect_valid = 1'b0;
        near();
        chk("midrst_cnt", 32'(count), 32'd0);
        chk("midrst_addr", imem_addr, 32'h0000_3000);

        // Randomized traffic with varying consumer pressure
        bias = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0:       bias = 10;
                    1:       bias = 50;
                    default: bias = 95;
                endcase
            end
            reset          = ($urandom_range(0, 199) == 0);
            int_req        = ($urandom_range(0, 59) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = pick_target();
            out_ready      = ($urandom_range(0, 99) < bias);
            tick();
        end
        reset = 1'b0;
        int_req = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        near();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, fetch address after reset.
REQ-002 Parameter EXC_PC, default 32'h0000_4180, fetch target on interrupt/exception request.
REQ-003 Parameter IM_LO, default 32'h0000_3000, lowest legal instruction address.
REQ-004 Parameter IM_HI, default 32'h0000_4FFC, highest legal instruction address.
REQ-005 Parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 imem_addr  out  32  current fetch PC to instruction memory.
REQ-009 imem_data  in  32  instruction at imem_addr, combinational, same cycle.
REQ-010 redirect_valid  in  1  branch/jump/eret redirect request.
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 int_req  in  1  interrupt/exception request; target EXC_PC.
REQ-013 out_valid  out  1  queue head valid.
REQ-014 out_ready  in  1  downstream accepts head.
REQ-015 out_pc  out  32  PC of head entry.
REQ-016 out_instr  out  32  instruction of head entry.
REQ-017 out_exc  out  1  head entry carries a fetch address exception.
REQ-018 count  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 fetch_pc register drives imem_addr; queue is a circular buffer of DEPTH entries {pc, instr, exc} with read/write pointers and occupancy counter.
REQ-020 fetch_exc = (fetch_pc[1:0] != 0) | (fetch_pc < IM_LO) | (fetch_pc > IM_HI), unsigned compare.
REQ-021 Pushed instr = 32'h0 when fetch_exc = 1, else imem_data; exc field = fetch_exc.
REQ-022 deq = out_valid & out_ready; push = (count < DEPTH | deq) & ~redirect_valid & ~int_req.
REQ-023 On push: entry written at write pointer, write pointer advances, fetch_pc <= fetch_pc + 4 (32-bit modular, 32'hFFFF_FFFC wraps to 0).
REQ-024 No push -> fetch_pc holds (queue full without dequeue stalls fetch).
REQ-025 out_valid = (count != 0) & ~redirect_valid & ~int_req; out_pc/out_instr/out_exc driven from read-pointer entry, combinational.
REQ-026 On deq: read pointer advances; push and deq in same cycle leave count unchanged, including when full.
REQ-027 Pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-028 int_req = 1: queue flushed (count, pointers <= 0), fetch_pc <= EXC_PC, no push, no deq; takes priority over redirect_valid.
REQ-029 redirect_valid = 1 and int_req = 0: queue flushed, fetch_pc <= redirect_pc, no push, no deq.
REQ-030 First push after flush occurs on next cycle, fetching from new target; latency redirect -> out_valid = 2 cycles.
REQ-031 redirect_pc that is misaligned/out of range is accepted; resulting entry has exc = 1, instr = 0, pc = redirect_pc, and fetch continues sequentially from it.
REQ-032 Latency reset deassert -> first out_valid = 1 cycle (fetch in cycle 0, head visible cycle 1).

Reset
REQ-033 reset = 1 at a clock edge: fetch_pc <= RESET_PC, pointers and count <= 0; reset overrides int_req, redirect and handshake.
REQ-034 During and after reset until first push: out_valid = 0, count = 0, imem_addr = RESET_PC; reset mid-operation discards all queued entries.

Verification
REQ-035 Reset, out_ready=1, memory returns addr-tagged data -> out_pc 3000, 3004, 3008 on consecutive cycles, out_exc = 0, count stays 1.
REQ-036 out_ready=0 for 10 cycles (DEPTH=4) -> count reaches 4, imem_addr holds 3010; then out_ready=1 -> out_pc 3000..300C in order, no entry lost or duplicated.
REQ-037 Queue full, out_ready=1 one cycle -> one deq and one push same cycle, count remains 4.
REQ-038 redirect_valid with redirect_pc=3400, queue holding 3 entries -> out_valid 0 that cycle, count 0 next, next head out_pc=3400.
REQ-039 int_req and redirect_valid (3400) same cycle -> next head out_pc=4180; redirect_pc=3002 -> head out_exc=1, out_instr=0; fetch reaching 4FFC then 5000 -> 5000 entry out_exc=1.
REQ-040 Reset asserted with full queue and redirect_valid=1 -> count 0, imem_addr 3000 after edge.
